// File: rtl/capture_reg_bank_pkg.sv
// capture_reg_bank_pkg: shared types for the capture register bank.
// Holds the run/freeze state encoding and its width so that the top module,
// the per-channel registers and any checker bound to state_o agree on it.
package capture_reg_bank_pkg;

  localparam int STATE_W = 2;

  // Encoding 3 is never produced; the next-state logic folds it back to IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

endpackage

// File: rtl/capture_reg_bank_chan.sv
// capture_chan: registers for one capture channel (last value, capture count,
// capture timestamp, wrapping running sum, sticky count-overflow flag).
// Optional feature macro: CAPTURE_REG_BANK_OVF_EN enables the overflow flag;
// when it is undefined ovf is a constant 0 and no overflow logic exists.
module capture_chan
  import capture_reg_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_cnt,
  input  logic             take,
  input  logic [WIDTH-1:0] data,
  input  logic [TS_W-1:0]  cycle,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt,
  output logic [TS_W-1:0]  ts,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  // Capture registers: q/ts follow every accepted capture, while a clear
  // outranks a same-cycle capture for the count and the running sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
      ts  <= '0;
      acc <= '0;
    end else begin
      if (take) begin
        q  <= data;
        ts <= cycle;
      end
      if (clr_cnt) begin
        cnt <= '0;
        acc <= '0;
      end else if (take) begin
        cnt <= cnt + 1'b1;
        acc <= acc + ACC_W'(data);
      end
    end
  end

`ifdef CAPTURE_REG_BANK_OVF_EN
  // Sticky overflow: set when a capture rolls cnt from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ovf <= 1'b0;
    end else if (take && (&cnt)) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/capture_reg_bank.sv
// capture_reg_bank: multi-channel capture register bank with a shared
// IDLE/RUN/FROZEN state machine and a free-running cycle counter.
// Optional feature macro: CAPTURE_REG_BANK_OVF_EN (per-channel sticky
// capture-count overflow flag; ovf reads 0 when the macro is undefined).
// ACC_W must be at least WIDTH so the zero-extended sample fits the sum.
//
// Handshake: channel c transfers on a rising edge where cap_valid[c] and
// cap_ready[c] are both high. cap_ready is a pure decode of the state
// register (high only in RUN), identical for all channels, and never
// depends on cap_valid. Results are visible one cycle after that edge.
module capture_reg_bank
  import capture_reg_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int TS_W     = 32,
  parameter int ACC_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      freeze,
  input  logic                      clr_cnt,
  input  logic [CHANNELS-1:0]       cap_valid,
  input  logic [CHANNELS*WIDTH-1:0] cap_data,
  output logic [CHANNELS-1:0]       cap_ready,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*CNT_W-1:0] cnt,
  output logic [CHANNELS*TS_W-1:0]  ts,
  output logic [CHANNELS*ACC_W-1:0] acc,
  output logic [TS_W-1:0]           cycle,
  output logic [CHANNELS-1:0]       ovf,
  output logic [STATE_W-1:0]        state_o
);

  state_t state;
  state_t state_nxt;
  logic   run;

  // State register; reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: start only matters in IDLE, freeze toggles RUN/FROZEN.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start  ? RUN    : IDLE;
      RUN:     state_nxt = freeze ? FROZEN : RUN;
      FROZEN:  state_nxt = freeze ? FROZEN : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Free-running cycle counter, counting in every state and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 1'b1;
    end
  end

  assign run       = (state == RUN);
  assign cap_ready = {CHANNELS{run}};
  assign state_o   = state;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    capture_chan #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .TS_W  (TS_W),
      .ACC_W (ACC_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .clr_cnt (clr_cnt),
      .take    (cap_valid[c] & run),
      .data    (cap_data[c*WIDTH +: WIDTH]),
      .cycle   (cycle),
      .q       (q[c*WIDTH +: WIDTH]),
      .cnt     (cnt[c*CNT_W +: CNT_W]),
      .ts      (ts[c*TS_W +: TS_W]),
      .acc     (acc[c*ACC_W +: ACC_W]),
      .ovf     (ovf[c])
    );
  end

endmodule

// File: tb/tb_capture_reg_bank.sv
// tb_capture_reg_bank: directed bench for capture_reg_bank with a
// scoreboard. Narrow CNT_W/ACC_W make counter and sum wrap reachable.
module tb_capture_reg_bank;
  import capture_reg_bank_pkg::*;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 2;
  localparam int TS_W     = 32;
  localparam int ACC_W    = 4;

`ifdef CAPTURE_REG_BANK_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      freeze = 1'b0;
  logic                      clr_cnt = 1'b0;
  logic [CHANNELS-1:0]       cap_valid = '0;
  logic [CHANNELS*WIDTH-1:0] cap_data = '0;
  logic [CHANNELS-1:0]       cap_ready;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*CNT_W-1:0] cnt;
  logic [CHANNELS*TS_W-1:0]  ts;
  logic [CHANNELS*ACC_W-1:0] acc;
  logic [TS_W-1:0]           cycle;
  logic [CHANNELS-1:0]       ovf;
  logic [1:0]                state_o;

  capture_reg_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .TS_W(TS_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze), .clr_cnt(clr_cnt),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .q(q), .cnt(cnt), .ts(ts), .acc(acc), .cycle(cycle), .ovf(ovf),
    .state_o(state_o)
  );

  // ---------------- expected mirror (hand-set by the tests) ----------------
  logic [3:0]  e_q   [2];
  logic [1:0]  e_cnt [2];
  logic [31:0] e_ts  [2];
  logic [3:0]  e_acc [2];
  logic [1:0]  e_ovf;
  logic [31:0] e_cycle;
  logic [1:0]  e_st;

  typedef struct packed {
    logic [7:0]  q;
    logic [3:0]  cnt;
    logic [63:0] ts;
    logic [7:0]  acc;
    logic [1:0]  ovf;
    logic [31:0] cyc;
    logic [1:0]  st;
    logic [1:0]  rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic clear_mirror();
    for (int c = 0; c < 2; c++) begin
      e_q[c] = '0; e_cnt[c] = '0; e_ts[c] = '0; e_acc[c] = '0;
    end
    e_ovf = '0; e_cycle = '0; e_st = IDLE;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs and queues the outputs expected after the
  // following rising edge (mirror must already hold the post-edge values).
  task automatic drive(input string nm, input logic r, input logic s,
                       input logic f, input logic c, input logic [1:0] v,
                       input logic [3:0] d0, input logic [3:0] d1);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; freeze = f; clr_cnt = c;
    cap_valid = v; cap_data = {d1, d0};
    e_cycle = r ? 32'd0 : e_cycle + 32'd1;
    e.q   = {e_q[1], e_q[0]};
    e.cnt = {e_cnt[1], e_cnt[0]};
    e.ts  = {e_ts[1], e_ts[0]};
    e.acc = {e_acc[1], e_acc[0]};
    e.ovf = e_ovf;
    e.cyc = e_cycle;
    e.st  = e_st;
    e.rdy = (e_st == RUN) ? 2'b11 : 2'b00;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic cmp(input string nm, input string fld,
                     input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp_v);
    end
  endtask

  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        cmp(nm, "q0",    64'(q[3:0]),    64'(e.q[3:0]));
        cmp(nm, "q1",    64'(q[7:4]),    64'(e.q[7:4]));
        cmp(nm, "cnt0",  64'(cnt[1:0]),  64'(e.cnt[1:0]));
        cmp(nm, "cnt1",  64'(cnt[3:2]),  64'(e.cnt[3:2]));
        cmp(nm, "ts0",   64'(ts[31:0]),  64'(e.ts[31:0]));
        cmp(nm, "ts1",   64'(ts[63:32]), 64'(e.ts[63:32]));
        cmp(nm, "acc0",  64'(acc[3:0]),  64'(e.acc[3:0]));
        cmp(nm, "acc1",  64'(acc[7:4]),  64'(e.acc[7:4]));
        cmp(nm, "ovf",   64'(ovf),       64'(e.ovf));
        cmp(nm, "cycle", 64'(cycle),     64'(e.cyc));
        cmp(nm, "state", 64'(state_o),   64'(e.st));
        cmp(nm, "ready", 64'(cap_ready), 64'(e.rdy));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed tests ----------------
  logic [3:0] wrap_acc [4];
  logic [1:0] wrap_cnt [4];

  initial begin
    wrap_acc = '{4'hF, 4'hE, 4'hD, 4'hC};
    wrap_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
    clear_mirror();

    // 1: reset (start/valid ignored under reset), then idle without start
    for (int i = 0; i < 5; i++) drive("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4'd9, 4'd9);
    for (int i = 0; i < 3; i++) drive("idle_ignore", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd9, 4'd9);

    // 2: start, then channel 0 captures 3 then 5
    e_st = RUN;
    drive("start", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    e_q[0] = 4'd3; e_cnt[0] = 2'd1; e_acc[0] = 4'd3; e_ts[0] = e_cycle;
    drive("cap3", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd3, 4'd0);
    e_q[0] = 4'd5; e_cnt[0] = 2'd2; e_acc[0] = 4'd8; e_ts[0] = e_cycle;
    drive("cap5", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd5, 4'd0);
    drive("start_in_run", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);

    // 3: freeze with valid held; capture on the freeze-sampling edge only
    e_st = FROZEN;
    e_q[0] = 4'd1; e_cnt[0] = 2'd3; e_acc[0] = 4'd9; e_ts[0] = e_cycle;
    drive("freeze_edge", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd1, 4'd0);
    drive("frozen_hold", 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 4'd2, 4'd0);
    drive("frozen_hold", 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd2, 4'd0);
    e_st = RUN;
    drive("unfreeze", 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd2, 4'd0);
    // cnt0 rolls 3 -> 0 here; channel 1 captures 6 alongside
    e_q[0] = 4'd2; e_cnt[0] = 2'd0; e_acc[0] = 4'hB; e_ts[0] = e_cycle;
    e_q[1] = 4'd6; e_cnt[1] = 2'd1; e_acc[1] = 4'd6; e_ts[1] = e_cycle;
    e_ovf = {1'b0, OVF_ON};
    drive("resume", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd2, 4'd6);

    // 5: clr_cnt coinciding with a capture of 7 on channel 0
    e_q[0] = 4'd7; e_ts[0] = e_cycle;
    e_cnt[0] = 2'd0; e_acc[0] = 4'd0; e_cnt[1] = 2'd0; e_acc[1] = 4'd0;
    e_ovf = 2'b00;
    drive("clr_cap", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd7, 4'd0);

    // 4: four captures of 0xF on both channels -> acc 0xC, cnt wraps to 0
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        e_q[c] = 4'hF; e_cnt[c] = wrap_cnt[i]; e_acc[c] = wrap_acc[i]; e_ts[c] = e_cycle;
      end
      if (i == 3) e_ovf = {OVF_ON, OVF_ON};
      drive("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF, 4'hF);
    end
    drive("ovf_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);

    // 6: reset during RUN with all channels valid
    clear_mirror();
    drive("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd3, 4'd3);
    drive("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'd3, 4'd3);

    // drain the scoreboard
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_reg_bank.md
Name: capture_reg_bank

Overview:
- Parametrised multi-channel successor to the single 4-bit capture flop; intended as a target for the $show VPI task.
- Each channel captures data through a valid/ready handshake and keeps per-channel state:
  - last value
  - capture count
  - capture timestamp
  - running sum
- A global run/freeze state machine and a free-running cycle counter are shared by all channels.
- Sits between a stimulus driver and the VPI inspection point in the test harness.

Parameters:
- WIDTH, 4, data bits per channel
- CHANNELS, 2, number of independent capture channels (1..16)
- CNT_W, 16, capture-counter width per channel
- TS_W, 32, cycle-counter and timestamp width
- ACC_W, 8, per-channel accumulator width (must be >= WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  IDLE->RUN request
- freeze  in  1  RUN->FROZEN request; deassert returns FROZEN->RUN
- clr_cnt  in  1  clears cnt, acc and ovf for all channels
- cap_valid  in  CHANNELS  per-channel capture request
- cap_data  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- cap_ready  out  CHANNELS  per-channel acceptance
- q  out  CHANNELS*WIDTH  last captured value
- cnt  out  CHANNELS*CNT_W  number of captures
- ts  out  CHANNELS*TS_W  cycle value at last capture
- acc  out  CHANNELS*ACC_W  wrapping sum of captured values
- cycle  out  TS_W  free-running cycle counter
- ovf  out  CHANNELS  sticky counter-overflow flag (see Optional Feature)
- state_o  out  2  current state encoding

Behaviour:
Reset (rst=1 at an edge) clears all outputs on that edge:
- q, cnt, ts, acc, cycle and ovf = 0
- state = IDLE
- cap_ready = 0

Reset applied mid-operation behaves identically, with no partial captures.

State machine (state_o encoding):
- IDLE=0: start -> RUN.
- RUN=1: freeze -> FROZEN.
- FROZEN=2: !freeze -> RUN.
- start is ignored outside IDLE; encoding 3 is unused and maps to IDLE.

Handshake and capture:
- cap_ready[c] = (state==RUN), combinational from the state register; all bits equal.
- Capture on channel c occurs at an edge where cap_valid[c] && cap_ready[c]:
  - q_c <= data
  - cnt_c <= cnt_c + 1
  - ts_c <= cycle (value before its increment)
  - acc_c <= acc_c + zero-extended data, wrapping modulo 2^ACC_W
- Latency: captured values appear on outputs one cycle after the accepting edge.
- Channels capture independently; any subset may capture in the same cycle.
- The freeze request takes effect at the next edge. A capture on the edge where freeze is first sampled is still accepted, because state is still RUN.

Cycle counter:
- cycle increments every edge when not in reset, in all states.
- It wraps from 2^TS_W-1 to 0.

Counters and clear:
- cnt wraps from 2^CNT_W-1 to 0.
- clr_cnt has priority over a same-cycle capture for cnt/acc/ovf:
  - cnt, acc and ovf become 0.
  - q and ts still update if a capture occurred.
- clr_cnt acts in any state.

Optional Feature:
Macro CAPTURE_REG_BANK_OVF_EN.
- Defined:
  - ovf[c] sets when a capture wraps cnt_c from all-ones to 0.
  - ovf is sticky until rst or clr_cnt.
- Undefined:
  - ovf is tied to 0 and no overflow logic is generated.
  - All other behaviour is identical.

Decomposition:
Package capture_reg_bank_pkg holds:
- the state enum (IDLE, RUN, FROZEN)
- the 2-bit state width constant

One sub-module is natural, capture_chan:
- per-channel q/cnt/ts/acc/ovf registers
- instantiated CHANNELS times in a generate loop

The state machine and cycle counter live in the top module.

Test Plan:
1. Reset then idle, defaults: hold rst 5 cycles, release, no start -> all outputs 0 except cycle counting 1,2,3...; cap_ready=0; captures with cap_valid=1 are ignored.
2. Basic capture: start, then channel 0 presents 3 then 5 on consecutive cycles -> q0=5, cnt0=2, acc0=8, ts0 = cycle at the second accept; channel 1 stays untouched.
3. Freeze: in RUN assert freeze with cap_valid held -> one capture on the freeze-sampling edge, then cap_ready=0 and cnt constant; deassert -> RUN and counting resumes.
4. Wrap: WIDTH=4, ACC_W=4, CNT_W=2; four captures of 0xF -> acc=0xC and cnt=0, with ovf=1 when OVF_EN is defined and 0 otherwise.
5. clr_cnt coinciding with a capture of 7 -> cnt=0, acc=0, q=7, ts updated.
6. Mid-run reset: rst during RUN with all channels valid -> next cycle all registers 0, state IDLE, no capture recorded.
